// File: rtl/bank_cmd_sequencer_pkg.sv
// mem_ctrl_pkg: shared types for the bank command sequencer.
//   dram_cmd_e   - command encoding seen by the DIMM command encoder
//   seq_state_e  - sequencer FSM state encoding
//   bank_lkp_e   - classification of a request against the open-row table
//   bank_state_t - per-bank open flag, open row and tRAS elapsed count
//   sat_inc()    - saturating increment used by all timing counters
package mem_ctrl_pkg;

  // Storage width for rows and timing counters; the sequencer's ROW_BITS and
  // T_* parameters must fit inside these.
  localparam int MAX_ROW_BITS = 16;
  localparam int CNT_W        = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    CMD_READ      = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_PRECHARGE = 3'd3
  } dram_cmd_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECIDE    = 3'd1,
    ISSUE_PRE = 3'd2,
    WAIT_RP   = 3'd3,
    ISSUE_ACT = 3'd4,
    WAIT_RCD  = 3'd5,
    ISSUE_RW  = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    LKP_CLOSED   = 2'd0,
    LKP_HIT      = 2'd1,
    LKP_CONFLICT = 2'd2
  } bank_lkp_e;

  typedef struct packed {
    logic                    is_open;
    logic [MAX_ROW_BITS-1:0] row;
    cnt_t                    tras_cnt;
  } bank_state_t;

  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
    return (v >= lim) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/bank_cmd_sequencer_if.sv
// bank_cmd_sequencer_if: request channel from the scheduler, command channel
// to the DIMM command encoder, and the busy indication.
//   slave  modport - the sequencer's view (takes requests, drives commands)
//   master modport - the surrounding scheduler/encoder view
interface bank_cmd_sequencer_if #(
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 4,
  parameter int BG_W     = 2,
  parameter int BA_W     = 1
);
  logic                req_valid_in;
  logic                req_ready_out;
  logic                req_write_in;
  logic [BG_W-1:0]     req_bg_in;
  logic [BA_W-1:0]     req_ba_in;
  logic [ROW_BITS-1:0] req_row_in;
  logic [COL_BITS-1:0] req_col_in;

  logic                cmd_valid_out;
  logic                cmd_ready_in;
  logic [2:0]          cmd_out;
  logic [BG_W-1:0]     cmd_bg_out;
  logic [BA_W-1:0]     cmd_ba_out;
  logic [ROW_BITS-1:0] cmd_row_out;
  logic [COL_BITS-1:0] cmd_col_out;

  logic                busy_out;

  modport slave (
    input  req_valid_in, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in,
    output req_ready_out,
    output cmd_valid_out, cmd_out, cmd_bg_out, cmd_ba_out, cmd_row_out, cmd_col_out,
    input  cmd_ready_in,
    output busy_out
  );

  modport master (
    output req_valid_in, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in,
    input  req_ready_out,
    input  cmd_valid_out, cmd_out, cmd_bg_out, cmd_ba_out, cmd_row_out, cmd_col_out,
    output cmd_ready_in,
    input  busy_out
  );
endinterface

// File: rtl/bank_cmd_sequencer_bank_state_table.sv
// bank_state_table: per-bank open flag, open row and saturating tRAS counter.
//   clk_in, rst_in    - clock, synchronous active-high reset (all banks closed,
//                       tRAS counters saturated)
//   lkp_bank_i/row_i  - bank/row being looked up
//   lkp_state_o       - closed / hit / conflict for that bank and row
//   lkp_tras_ok_o     - the looked-up bank may be precharged
//   act_en_i          - ACT accepted for upd_bank_i: open it on upd_row_i
//   pre_en_i          - PRE accepted for upd_bank_i: close it
module bank_state_table
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ROW_BITS  = 8,
  parameter int T_RAS     = 8,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [BANK_W-1:0]   lkp_bank_i,
  input  logic [ROW_BITS-1:0] lkp_row_i,
  output bank_lkp_e           lkp_state_o,
  output logic                lkp_tras_ok_o,
  input  logic                act_en_i,
  input  logic                pre_en_i,
  input  logic [BANK_W-1:0]   upd_bank_i,
  input  logic [ROW_BITS-1:0] upd_row_i
);

  localparam cnt_t TRAS_LIM = cnt_t'(T_RAS);

  bank_state_t tbl_q [NUM_BANKS];
  bank_state_t tbl_d [NUM_BANKS];
  bank_state_t cur;

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      tbl_d[i]          = tbl_q[i];
      tbl_d[i].tras_cnt = sat_inc(tbl_q[i].tras_cnt, TRAS_LIM);
      if (act_en_i && (upd_bank_i == BANK_W'(i))) begin
        tbl_d[i].is_open  = 1'b1;
        tbl_d[i].row      = MAX_ROW_BITS'(upd_row_i);
        // The ACT handshake cycle itself counts as elapsed cycle 0, so the
        // register holds 1 on the following cycle and reaches T_RAS exactly
        // T_RAS cycles after the handshake.
        tbl_d[i].tras_cnt = cnt_t'(1);
      end
      if (pre_en_i && (upd_bank_i == BANK_W'(i))) begin
        tbl_d[i].is_open = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        tbl_q[i] <= '{is_open: 1'b0, row: '0, tras_cnt: TRAS_LIM};
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign cur = tbl_q[lkp_bank_i];

  always_comb begin
    lkp_state_o = LKP_CLOSED;
    if (cur.is_open) begin
      lkp_state_o = (cur.row == MAX_ROW_BITS'(lkp_row_i)) ? LKP_HIT : LKP_CONFLICT;
    end
  end

  assign lkp_tras_ok_o = (cur.tras_cnt >= TRAS_LIM);

endmodule

// File: rtl/bank_cmd_sequencer.sv
// bank_cmd_sequencer: single-request-in-flight DRAM command sequencer with an
// open-page policy. Turns one request into PRE/ACT/RD/WR as needed while
// honouring tRP, tRCD, tRAS (per bank) and tCCD (global).
//   clk_in, rst_in - clock, synchronous active-high reset
//   bus (slave)    - req_* request channel, cmd_* command channel, busy_out
//
// state     | meaning
// IDLE      | ready for a request
// DECIDE    | classify latched request against the open-row table
// ISSUE_PRE | PRE offered once tRAS of the target bank is met
// WAIT_RP   | counting tRP after the PRE handshake
// ISSUE_ACT | ACT offered for the latched row
// WAIT_RCD  | counting tRCD after the ACT handshake
// ISSUE_RW  | RD/WR offered once tCCD is met
module bank_cmd_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 4,
  parameter int BANK_GROUPS     = 4,
  parameter int BANKS_PER_GROUP = 2,
  parameter int T_RP            = 4,
  parameter int T_RCD           = 4,
  parameter int T_RAS           = 8,
  parameter int T_CCD           = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  bank_cmd_sequencer_if.slave bus
);

  localparam int BG_W      = $clog2(BANK_GROUPS);
  localparam int BA_W      = $clog2(BANKS_PER_GROUP);
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_DECIDE    = DECIDE;
  localparam logic [2:0] ST_ISSUE_PRE = ISSUE_PRE;
  localparam logic [2:0] ST_WAIT_RP   = WAIT_RP;
  localparam logic [2:0] ST_ISSUE_ACT = ISSUE_ACT;
  localparam logic [2:0] ST_WAIT_RCD  = WAIT_RCD;
  localparam logic [2:0] ST_ISSUE_RW  = ISSUE_RW;

  // The wait states span T-1 cycles (handshake cycle + wait cycles = T), and
  // the down-counter leaves on terminal count 0, hence the load of T-2.
  localparam cnt_t RP_LOAD  = cnt_t'(T_RP - 2);
  localparam cnt_t RCD_LOAD = cnt_t'(T_RCD - 2);
  localparam cnt_t CCD_LIM  = cnt_t'(T_CCD);

  logic [2:0]          state_q, state_d;
  cnt_t                wait_q, wait_d;
  cnt_t                tccd_q, tccd_d;
  logic                write_q;
  logic [BG_W-1:0]     bg_q;
  logic [BA_W-1:0]     ba_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;

  logic                req_hs;
  logic                cmd_hs;
  logic                cmd_valid;
  dram_cmd_e           cmd;
  logic [BANK_W-1:0]   bank_idx;
  bank_lkp_e           lkp;
  logic                tras_ok;
  logic                act_en;
  logic                pre_en;

  assign bus.req_ready_out = (state_q == ST_IDLE) & ~rst_in;
  assign req_hs            = bus.req_valid_in & bus.req_ready_out;
  assign cmd_hs            = cmd_valid & bus.cmd_ready_in;
  assign bank_idx          = BANK_W'(bg_q) * BANK_W'(BANKS_PER_GROUP) + BANK_W'(ba_q);

  bank_state_table #(
    .NUM_BANKS (NUM_BANKS),
    .ROW_BITS  (ROW_BITS),
    .T_RAS     (T_RAS)
  ) u_bank_tbl (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .lkp_bank_i    (bank_idx),
    .lkp_row_i     (row_q),
    .lkp_state_o   (lkp),
    .lkp_tras_ok_o (tras_ok),
    .act_en_i      (act_en),
    .pre_en_i      (pre_en),
    .upd_bank_i    (bank_idx),
    .upd_row_i     (row_q)
  );

  // Valid depends only on registered state and monotonically rising counters,
  // so once raised it holds until the handshake.
  always_comb begin
    cmd_valid = 1'b0;
    cmd       = CMD_READ;
    case (state_q)
      ST_ISSUE_PRE: begin
        cmd_valid = tras_ok;
        cmd       = CMD_PRECHARGE;
      end
      ST_ISSUE_ACT: begin
        cmd_valid = 1'b1;
        cmd       = CMD_ACTIVATE;
      end
      ST_ISSUE_RW: begin
        cmd_valid = (tccd_q >= CCD_LIM);
        cmd       = write_q ? CMD_WRITE : CMD_READ;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tccd_d  = sat_inc(tccd_q, CCD_LIM);
    act_en  = 1'b0;
    pre_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        case (lkp)
          LKP_HIT:    state_d = ST_ISSUE_RW;
          LKP_CLOSED: state_d = ST_ISSUE_ACT;
          default:    state_d = ST_ISSUE_PRE;
        endcase
      end
      ST_ISSUE_PRE: begin
        if (cmd_hs) begin
          pre_en  = 1'b1;
          wait_d  = RP_LOAD;
          state_d = ST_WAIT_RP;
        end
      end
      ST_WAIT_RP: begin
        if (wait_q == '0) state_d = ST_ISSUE_ACT;
        else              wait_d  = wait_q - cnt_t'(1);
      end
      ST_ISSUE_ACT: begin
        if (cmd_hs) begin
          act_en  = 1'b1;
          wait_d  = RCD_LOAD;
          state_d = ST_WAIT_RCD;
        end
      end
      ST_WAIT_RCD: begin
        if (wait_q == '0) state_d = ST_ISSUE_RW;
        else              wait_d  = wait_q - cnt_t'(1);
      end
      ST_ISSUE_RW: begin
        if (cmd_hs) begin
          // Same elapsed-count convention as tRAS: handshake cycle is cycle 0.
          tccd_d  = cnt_t'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      tccd_q  <= CCD_LIM;
      write_q <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tccd_q  <= tccd_d;
      if (req_hs) begin
        write_q <= bus.req_write_in;
        bg_q    <= bus.req_bg_in;
        ba_q    <= bus.req_ba_in;
        row_q   <= bus.req_row_in;
        col_q   <= bus.req_col_in;
      end
    end
  end

  assign bus.cmd_valid_out = cmd_valid;
  assign bus.cmd_out       = cmd;
  assign bus.cmd_bg_out    = bg_q;
  assign bus.cmd_ba_out    = ba_q;
  assign bus.cmd_row_out   = row_q;
  assign bus.cmd_col_out   = col_q;
  assign bus.busy_out      = (state_q != ST_IDLE);

endmodule
